// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged reset release with ready handshake, bounded retry and sticky fault
module reset_sequencer #(
    parameter int NUM_STAGES    = 3,
    parameter int STAGE_DELAY   = 16,
    parameter int READY_TIMEOUT = 4096,
    parameter int MAX_RETRY     = 2
) (
    input  logic                  clk_i,
    input  logic                  resetn_i,
    input  logic [NUM_STAGES-1:0] stage_ready_i,
    output logic [NUM_STAGES-1:0] rst_stage_n_o,
    output logic                  seq_done_o,
    output logic                  timeout_err_o,
    output logic [2:0]            fail_stage_o,
    output logic                  busy_o
);

    localparam int CNT_MAX = (STAGE_DELAY > READY_TIMEOUT) ? STAGE_DELAY : READY_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX);

    localparam logic [CW-1:0] DELAY_LAST   = CW'(STAGE_DELAY - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(READY_TIMEOUT - 1);
    localparam logic [2:0]    LAST_IDX     = 3'(NUM_STAGES - 1);
    localparam logic [3:0]    RETRY_MAX    = 4'(MAX_RETRY);

    typedef enum logic [1:0] {
        S_DELAY,
        S_WAIT,
        S_DONE,
        S_FAULT
    } state_t;

    state_t                state;
    logic [2:0]            idx;
    logic [CW-1:0]         cnt;
    logic [3:0]            retry;
    logic [NUM_STAGES-1:0] stage_mask;
    logic                  ready_sel;

    // One-hot of the active stage; only its ready bit is ever looked at.
    assign stage_mask = NUM_STAGES'(1) << idx;
    assign ready_sel  = |(stage_ready_i & stage_mask);

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state         <= S_DELAY;
            idx           <= '0;
            cnt           <= '0;
            retry         <= '0;
            rst_stage_n_o <= '0;
            seq_done_o    <= 1'b0;
            timeout_err_o <= 1'b0;
            fail_stage_o  <= '0;
            busy_o        <= 1'b1;
        end else begin
            case (state)
                S_DELAY: begin
                    if (cnt == DELAY_LAST) begin
                        rst_stage_n_o <= rst_stage_n_o | stage_mask;
                        cnt           <= '0;
                        state         <= S_WAIT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    // Ready takes priority over a coincident timeout.
                    if (ready_sel) begin
                        if (idx == LAST_IDX) begin
                            seq_done_o <= 1'b1;
                            busy_o     <= 1'b0;
                            state      <= S_DONE;
                        end else begin
                            idx   <= idx + 3'd1;
                            retry <= '0;
                            cnt   <= '0;
                            state <= S_DELAY;
                        end
                    end else if (cnt == TIMEOUT_LAST) begin
                        rst_stage_n_o <= rst_stage_n_o & ~stage_mask;
                        cnt           <= '0;
                        if (retry < RETRY_MAX) begin
                            retry <= retry + 4'd1;
                            state <= S_DELAY;
                        end else begin
                            timeout_err_o <= 1'b1;
                            fail_stage_o  <= idx;
                            busy_o        <= 1'b0;
                            state         <= S_FAULT;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    // DONE and FAULT are terminal until the next reset.
                end
            endcase
        end
    end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Downstream consumer of the system synchronous reset. Takes the stable reset (Resetn) and releases the oscilloscope subsystems (ADC interface, sample buffer/trigger, display) one after another.
- Each stage is released only after the previous stage reports ready and a fixed settle delay has elapsed.
- A ready timeout triggers bounded retries of the failing stage. If retries run out, the block enters a sticky fault.

Parameters:
- NUM_STAGES, 3, number of sequenced reset outputs (1..8).
- STAGE_DELAY, 16, clk_i cycles from entering DELAY to releasing the stage (>=2).
- READY_TIMEOUT, 4096, clk_i cycles allowed in WAIT_READY before a timeout (>=2).
- MAX_RETRY, 2, number of retries per stage before FAULT (0..15).

Ports:
- clk_i  input  1  system clock (12 MHz BUFG domain).
- resetn_i  input  1  asynchronous, active-low reset (driven by the system Resetn).
- stage_ready_i  input  NUM_STAGES  per-stage ready/calibrated flags; synchronous to clk_i.
- rst_stage_n_o  output  NUM_STAGES  per-stage active-low resets, registered.
- seq_done_o  output  1  high once all stages are released and have reported ready.
- timeout_err_o  output  1  sticky fault flag.
- fail_stage_o  output  3  index of the stage that faulted; valid while timeout_err_o=1.
- busy_o  output  1  high while in DELAY or WAIT_READY.

Behaviour:
- Reset (resetn_i=0, asynchronous):
  - rst_stage_n_o=all 0, seq_done_o=0, timeout_err_o=0, fail_stage_o=0, busy_o=1.
  - state=DELAY, idx=0, cnt=0, retry=0.
- Edge numbering: edge 1 is the first rising clk_i edge with resetn_i=1.
- States: DELAY, WAIT_READY, DONE, FAULT. All outputs are registered and update on the same edge as the transition.
- DELAY:
  - cnt increments each edge.
  - On the edge where cnt==STAGE_DELAY-1: set rst_stage_n_o[idx]=1, clear cnt, go to WAIT_READY.
- WAIT_READY:
  - stage_ready_i[idx] is sampled each edge.
  - If it is 1 and idx<NUM_STAGES-1: idx++, retry=0, cnt=0, go to DELAY.
  - If it is 1 and idx=NUM_STAGES-1: go to DONE and set seq_done_o=1 on that edge.
  - Else if cnt==READY_TIMEOUT-1 (timeout):
    - If retry<MAX_RETRY: rst_stage_n_o[idx]=0, retry++, cnt=0, go to DELAY for the same idx.
    - Otherwise: rst_stage_n_o[idx]=0, timeout_err_o=1, fail_stage_o=idx, go to FAULT.
  - Else: cnt++.
  - If ready and the timeout condition occur on the same edge, ready wins.
- Ready gating: stage_ready_i bits for stages not currently in WAIT_READY are ignored. An early ready (already high before release) is accepted on the first WAIT_READY edge.
- DONE:
  - Terminal state; holds until reset.
  - seq_done_o=1, busy_o=0.
  - Later drops of stage_ready_i are ignored, with no re-sequencing.
- FAULT:
  - Terminal state; holds until reset.
  - Stages below fail_stage_o stay released; stage fail_stage_o and all later stages stay in reset.
  - seq_done_o=0, busy_o=0.
- Already-released stages are never re-asserted by a retry of a later stage.
- Reset mid-operation: any resetn_i=0, in any state, asynchronously returns every output and all state to the reset values above. The sequence restarts from stage 0 after resetn_i deasserts.
- Counter width: clog2(max(STAGE_DELAY, READY_TIMEOUT)). No wrap is possible because cnt is always cleared at its terminal value.
- Retry counter width: 4 bits.

Test Plan:
- Defaults, stage_ready_i tied to 3'b111:
  - rst_stage_n_o[0] rises at edge 16, [1] at edge 33, [2] at edge 50.
  - seq_done_o rises at edge 51; busy_o falls at edge 51.
- stage_ready_i[1] asserted 100 cycles after its release (edge 133):
  - rst_stage_n_o[2] rises at edge 150.
  - No retry occurs and timeout_err_o stays 0.
- stage_ready_i[0] never asserts:
  - Releases at edges 16, 4128 and 8240; re-assertions at edges 4112 and 8224.
  - At edge 12336: timeout_err_o=1, fail_stage_o=0, rst_stage_n_o=3'b000, and the state holds for 1000+ further cycles.
- Stage 1 fails once, then ready arrives 10 cycles after its second release:
  - Stage 1 is re-asserted at edge 33+4096=4129 and released again at edge 4145.
  - rst_stage_n_o[0] stays 1 throughout, and seq_done_o is eventually set.
- resetn_i pulsed low for 3 cycles at edge 40 (during stage 1 WAIT_READY):
  - rst_stage_n_o is forced to 000 immediately (asynchronously).
  - After deassertion the sequence repeats the scenario-1 timing.
- Glitch on stage_ready_i[2] while stage 1 is in DELAY:
  - No effect; stage 2 is still released exactly STAGE_DELAY edges after stage 1 reports ready.
